// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        SKID,
        DRAIN
    } state_e;

    localparam int unsigned PC_INC      = 4;
    localparam int unsigned PC_AHEAD    = 8;
    localparam logic [31:0] INSTR_RESET = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/ack plus the decode-side slot.
interface fetch_unit_if #(
    parameter int unsigned PC_W = 32
) ();

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic [PC_W-1:0] r15;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, r15,
        input  imem_ack, imem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, r15,
        output imem_ack, imem_rdata, stall, branch_taken, branch_target
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction word and its PC.
module fetch_skid_buf #(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            clear,
    input  logic [31:0]     din_instr,
    input  logic [PC_W-1:0] din_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = din_instr;
            pc_d    = din_pc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack, decode slot with skid, branch flush.
// Optional FETCH_PERF_CNT_EN adds fetch_count/flush_count outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_count,
    output logic [31:0]   flush_count
`endif
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            active_q, active_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;

    logic            req, ack, transfer, slot_free;
    logic [PC_W-1:0] tgt_clean;
    logic            skid_load, skid_unload, skid_clear, skid_valid;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;

    fetch_skid_buf #(.PC_W(PC_W)) u_skid (
        .clk       (clk),
        .rst       (reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .din_instr (bus.imem_rdata),
        .din_pc    (pc_q),
        .valid     (skid_valid),
        .instr     (skid_instr),
        .pc        (skid_pc)
    );

    // active_q holds the request low for the first cycle out of reset.
    assign req       = active_q && (state_q != SKID);
    assign ack       = bus.imem_ack && req;
    assign transfer  = out_valid_q && !bus.stall;
    assign slot_free = !out_valid_q || transfer;
    assign tgt_clean = bus.branch_target & ~PC_W'(3);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        active_d    = 1'b1;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (transfer) out_valid_d = 1'b0;

        if (bus.branch_taken) begin
            out_valid_d = 1'b0;
            skid_clear  = 1'b1;
            // An unacked request must complete before the target can be issued.
            if (req && !ack) begin
                state_d = DRAIN;
                tgt_d   = tgt_clean;
            end else begin
                state_d = FETCH;
                pc_d    = tgt_clean;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_q + PC_W'(PC_INC);
                        if (slot_free) begin
                            out_valid_d = 1'b1;
                            instr_d     = bus.imem_rdata;
                            instr_pc_d  = pc_q;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = SKID;
                        end
                    end
                end
                SKID: begin
                    if (transfer && skid_valid) begin
                        out_valid_d = 1'b1;
                        instr_d     = skid_instr;
                        instr_pc_d  = skid_pc;
                        skid_unload = 1'b1;
                        state_d     = FETCH;
                    end
                end
                DRAIN: begin
                    if (ack) begin
                        pc_d    = tgt_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            active_q    <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= INSTR_RESET;
            instr_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            active_q    <= active_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = out_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.r15         = instr_pc_q + PC_W'(PC_AHEAD);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, transfer};
        flush_cnt_d = flush_cnt_q + {31'd0, bus.branch_taken};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with RESET_PC = 0x100.
module tb_fetch_unit;

    localparam logic [31:0] RPC     = 32'h0000_0100;
    localparam int          NROWS   = 24;
    localparam int          RST_ROW = 19;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_unit_if #(.PC_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
    int          exp_fetch;
    int          exp_flush;
`endif

    fetch_unit #(
        .PC_W     (32),
        .RESET_PC (RPC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        br;
        logic        ack;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t v [NROWS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " imem_req"},    {31'd0, bus.imem_req},    32'd0);
        chk({tag, " imem_addr"},   bus.imem_addr,            RPC);
        chk({tag, " instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        chk({tag, " instr"},       bus.instr,                32'd0);
        chk({tag, " instr_pc"},    bus.instr_pc,             RPC);
        chk({tag, " r15"},         bus.r15,                  RPC + 32'd8);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, " fetch_count"}, fetch_count, 32'd0);
        chk({tag, " flush_count"}, flush_count, 32'd0);
`endif
    endtask

    task automatic drive_idle();
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'd0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
    endtask

    initial begin
        //                stall br  ack  target         req  addr           vld  pc
        v[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0100, 1'b0, 32'h0};
        v[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0};
        v[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
        v[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100};
        v[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100};
        v[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100};
        v[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104};
        v[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_2002, 1'b1, 32'h0000_0108, 1'b0, 32'h0};
        v[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 1'b0, 32'h0};
        v[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_0108, 1'b0, 32'h0};
        v[10] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_2000, 1'b0, 32'h0};
        v[11] = '{1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_2004, 1'b1, 32'h0000_2000};
        v[12] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 32'h0};
        v[13] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_3004, 1'b1, 32'h0000_3000};
        v[14] = '{1'b1, 1'b1, 1'b0, 32'h0000_4001, 1'b0, 32'h0000_3008, 1'b1, 32'h0000_3000};
        v[15] = '{1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0000_4000, 1'b0, 32'h0};
        v[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_4004, 1'b1, 32'h0000_4000};
        v[17] = '{1'b0, 1'b1, 1'b0, 32'h0000_5000, 1'b1, 32'h0000_4004, 1'b0, 32'h0};
        v[18] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_4004, 1'b0, 32'h0};
        // after the mid-DRAIN reset: branch with coincident ack, then PC wrap
        v[19] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0100, 1'b0, 32'h0};
        v[20] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
        v[21] = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        v[22] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
        v[23] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0};

        checks = 0;
        errors = 0;
`ifdef FETCH_PERF_CNT_EN
        exp_fetch = 0;
        exp_flush = 0;
`endif
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        for (int i = 0; i < NROWS; i++) begin
            if (i == RST_ROW) begin
                // asynchronous reset mid-cycle while DRAIN is waiting on an ack
                #2 reset = 1'b1;
                drive_idle();
                #1 check_reset_vals("mid_drain_reset");
`ifdef FETCH_PERF_CNT_EN
                exp_fetch = 0;
                exp_flush = 0;
`endif
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
            end

            chk($sformatf("row%0d imem_req", i), {31'd0, bus.imem_req}, {31'd0, v[i].e_req});
            chk($sformatf("row%0d imem_addr", i), bus.imem_addr, v[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), {31'd0, bus.instr_valid}, {31'd0, v[i].e_vld});
            if (v[i].e_vld) begin
                chk($sformatf("row%0d instr_pc", i), bus.instr_pc, v[i].e_pc);
                chk($sformatf("row%0d instr", i), bus.instr, mem_word(v[i].e_pc));
                chk($sformatf("row%0d r15", i), bus.r15, v[i].e_pc + 32'd8);
            end

`ifdef FETCH_PERF_CNT_EN
            if (v[i].e_vld && !v[i].stall) exp_fetch++;
            if (v[i].br) exp_flush++;
`endif
            bus.stall         = v[i].stall;
            bus.branch_taken  = v[i].br;
            bus.branch_target = v[i].tgt;
            bus.imem_ack      = v[i].ack;
            bus.imem_rdata    = v[i].ack ? mem_word(bus.imem_addr) : 32'd0;
            @(negedge clk);
        end

`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count end", fetch_count, exp_fetch);
        chk("flush_count end", flush_count, exp_flush);
`endif
        drive_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
